wolfram_row_stepper: RTL and testbench

WOLFRAM_ROW_STEPPER -- requirements
Module: wolfram_row_stepper

---
 rtl/wolfram_pkg.sv | 26 ++
 rtl/wolfram_nbhd_mux.sv | 37 +++
 rtl/wolfram_row_stepper.sv | 147 ++++++++++++++
 tb/tb_wolfram_row_stepper.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/wolfram_pkg.sv
// ============================================================================
// wolfram_pkg -- shared FSM encoding and WIDTH limits for the row stepper
// Rev 1.0
// ============================================================================
`default_nettype none

package wolfram_pkg;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic int idx_bits(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wolfram_nbhd_mux.sv
// ============================================================================
// wolfram_nbhd_mux -- selects the toroidally wrapped {left,centre,right} cells
// Rev 1.0
// ============================================================================
`default_nettype none

module wolfram_nbhd_mux
  import wolfram_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDXW  = idx_bits(WIDTH)
) (
  input  logic [WIDTH-1:0] row,
  input  logic [IDXW-1:0]  idx,
  output logic             left,
  output logic             centre,
  output logic             right
);

  localparam logic [IDXW-1:0] c_last = IDXW'(WIDTH - 1);

  logic [IDXW-1:0] w_left_idx;
  logic [IDXW-1:0] w_right_idx;

  // Left is the higher-numbered cell; both ends wrap around the ring.
  always_comb begin
    w_left_idx  = (idx == c_last) ? '0 : idx + 1'b1;
    w_right_idx = (idx == '0) ? c_last : idx - 1'b1;
  end

  assign left   = row[w_left_idx];
  assign centre = row[idx];
  assign right  = row[w_right_idx];

endmodule

`default_nettype wire

// File: rtl/wolfram_row_stepper.sv
// ============================================================================
// wolfram_row_stepper -- serial elementary-CA row stepper using an external rule gate
// Rev 1.0
// ============================================================================
`default_nettype none

module wolfram_row_stepper
  import wolfram_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [7:0]       gens,
  output logic             nb_in1,
  output logic             nb_in2,
  output logic             nb_in3,
  input  logic             nb_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] row,
  output logic [7:0]       gen_count
);

  localparam int              IDXW       = idx_bits(WIDTH);
  localparam logic [IDXW-1:0] c_last_idx = IDXW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("wolfram_row_stepper: WIDTH out of range");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_next;
  logic [IDXW-1:0]  r_idx;
  logic [7:0]       r_gens;

  logic [WIDTH-1:0] w_mux_row;
  logic [IDXW-1:0]  w_mux_idx;
  logic             w_left;
  logic             w_centre;
  logic             w_right;
  logic [7:0]       w_gen_next;

  // The nb_* outputs are registered, so the mux looks at the row and index
  // that will be current in the upcoming DRIVE cycle.
  always_comb begin
    w_mux_row = r_work;
    w_mux_idx = '0;
    case (r_state)
      S_IDLE:   w_mux_row = seed;
      S_SAMPLE: w_mux_idx = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
      S_COMMIT: w_mux_row = r_next;
      default:  ;
    endcase
  end

  assign w_gen_next = gen_count + 8'd1;

  wolfram_nbhd_mux #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_nbhd_mux (
    .row    (w_mux_row),
    .idx    (w_mux_idx),
    .left   (w_left),
    .centre (w_centre),
    .right  (w_right)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_next    <= '0;
      r_idx     <= '0;
      r_gens    <= '0;
      row       <= '0;
      gen_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nb_in1    <= 1'b0;
      nb_in2    <= 1'b0;
      nb_in3    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work    <= seed;
            row       <= seed;
            gen_count <= '0;
            r_idx     <= '0;
            r_gens    <= gens;
            busy      <= 1'b1;
            if (gens == 8'd0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= S_DRIVE;
              {nb_in1, nb_in2, nb_in3} <= {w_left, w_centre, w_right};
            end
          end
        end
        S_DRIVE: r_state <= S_SAMPLE;
        S_SAMPLE: begin
          r_next[r_idx] <= nb_out;
          if (r_idx == c_last_idx) begin
            r_state <= S_COMMIT;
            {nb_in1, nb_in2, nb_in3} <= 3'b000;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_DRIVE;
            {nb_in1, nb_in2, nb_in3} <= {w_left, w_centre, w_right};
          end
        end
        S_COMMIT: begin
          r_work    <= r_next;
          row       <= r_next;
          gen_count <= w_gen_next;
          r_idx     <= '0;
          if (w_gen_next == r_gens) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_state <= S_DRIVE;
            {nb_in1, nb_in2, nb_in3} <= {w_left, w_centre, w_right};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          {nb_in1, nb_in2, nb_in3} <= 3'b000;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wolfram_row_stepper.sv
// ============================================================================
// tb_wolfram_row_stepper -- directed-vector bench, WIDTH=8 with rule table 0x79
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wolfram_row_stepper;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] seed = '0;
  logic [7:0]       gens = '0;
  logic             nb_in1, nb_in2, nb_in3, nb_out;
  logic             busy, done;
  logic [WIDTH-1:0] row;
  logic [7:0]       gen_count;
  logic [7:0]       rule_tt = 8'h79;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // Table is listed MSB-first: neighbourhood {l,c,r}=000 selects bit 7.
  assign nb_out = rule_tt[~{nb_in1, nb_in2, nb_in3}];

  wolfram_row_stepper #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .gens      (gens),
    .nb_in1    (nb_in1),
    .nb_in2    (nb_in2),
    .nb_in3    (nb_in3),
    .nb_out    (nb_out),
    .busy      (busy),
    .done      (done),
    .row       (row),
    .gen_count (gen_count)
  );

  // Pulses start, then watches the run: lat is the cycle offset of the first
  // done (-1 if none within budget). Optional extra start pulses mid-run
  // (poke_at) and in the done cycle (poke_done).
  task automatic launch(input logic [7:0] s, input logic [7:0] g,
                        input int poke_at, input bit poke_done,
                        output int lat, output int pulses, output int nb_active,
                        output logic [2:0] nb1, output logic [2:0] nb2,
                        output logic [2:0] nb15);
    int n;
    int tail;
    lat = -1; pulses = 0; nb_active = 0; tail = 0;
    nb1 = '0; nb2 = '0; nb15 = '0;
    @(negedge clk);
    seed = s; gens = g; start = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 600 && tail < 4) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (poke_at == n) begin
        start = 1'b1; seed = 8'hC3; gens = 8'd5;
      end
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          if (poke_done) begin
            start = 1'b1; seed = 8'hC3; gens = 8'd0;
          end
        end
      end
      if ({nb_in1, nb_in2, nb_in3} != 3'b000) nb_active++;
      if (n == 1)  nb1  = {nb_in1, nb_in2, nb_in3};
      if (n == 2)  nb2  = {nb_in1, nb_in2, nb_in3};
      if (n == 15) nb15 = {nb_in1, nb_in2, nb_in3};
      if (lat >= 0) tail++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (row !== 8'h00) begin errors++; $display("FAIL reset_row: got %h expected 00", row); end
    vectors++; if (gen_count !== 8'h00) begin errors++; $display("FAIL reset_gen_count: got %h expected 00", gen_count); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    vectors++; if ({nb_in1, nb_in2, nb_in3} !== 3'b000) begin errors++; $display("FAIL reset_nb: got %b expected 000", {nb_in1, nb_in2, nb_in3}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_gen();
    int lat, pulses, nba;
    logic [2:0] n1, n2, n15;
    launch(8'h10, 8'd1, 0, 1'b0, lat, pulses, nba, n1, n2, n15);
    vectors++; if (lat !== 18) begin errors++; $display("FAIL single_latency: got %0d expected 18", lat); end
    vectors++; if (row !== 8'h38) begin errors++; $display("FAIL single_row: got %h expected 38", row); end
    vectors++; if (gen_count !== 8'd1) begin errors++; $display("FAIL single_gen_count: got %0d expected 1", gen_count); end
    vectors++; if (pulses !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    int lat, pulses, nba;
    logic [2:0] n1, n2, n15;
    launch(8'h01, 8'd1, 0, 1'b0, lat, pulses, nba, n1, n2, n15);
    vectors++; if (row !== 8'h83) begin errors++; $display("FAIL wrap_row: got %h expected 83", row); end
    vectors++; if (n1 !== 3'b010) begin errors++; $display("FAIL wrap_nb_cell0_drive: got %b expected 010", n1); end
    vectors++; if (n2 !== 3'b010) begin errors++; $display("FAIL wrap_nb_cell0_sample: got %b expected 010", n2); end
    vectors++; if (n15 !== 3'b100) begin errors++; $display("FAIL wrap_nb_cell7_drive: got %b expected 100", n15); end
  endtask

  task automatic test_uniform();
    logic [7:0] seeds [2] = '{8'h00, 8'hFF};
    int lat, pulses, nba;
    logic [2:0] n1, n2, n15;
    for (int i = 0; i < 2; i++) begin
      launch(seeds[i], 8'd3, 0, 1'b0, lat, pulses, nba, n1, n2, n15);
      vectors++; if (lat !== 52) begin errors++; $display("FAIL uniform_latency seed %h: got %0d expected 52", seeds[i], lat); end
      vectors++; if (row !== seeds[i]) begin errors++; $display("FAIL uniform_row seed %h: got %h expected %h", seeds[i], row, seeds[i]); end
      vectors++; if (gen_count !== 8'd3) begin errors++; $display("FAIL uniform_gen_count seed %h: got %0d expected 3", seeds[i], gen_count); end
    end
  endtask

  task automatic test_zero_gens();
    int lat, pulses, nba;
    logic [2:0] n1, n2, n15;
    launch(8'h5A, 8'd0, 0, 1'b0, lat, pulses, nba, n1, n2, n15);
    vectors++; if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    vectors++; if (row !== 8'h5A) begin errors++; $display("FAIL zero_row: got %h expected 5a", row); end
    vectors++; if (gen_count !== 8'd0) begin errors++; $display("FAIL zero_gen_count: got %0d expected 0", gen_count); end
    vectors++; if (nba !== 0) begin errors++; $display("FAIL zero_nb_activity: got %0d cycles expected 0", nba); end
    vectors++; if (pulses !== 1) begin errors++; $display("FAIL zero_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int lat, pulses, nba;
    logic [2:0] n1, n2, n15;
    // Two generations from 0x10: 0x10 -> 0x38 -> 0x74.
    launch(8'h10, 8'd2, 7, 1'b1, lat, pulses, nba, n1, n2, n15);
    vectors++; if (lat !== 35) begin errors++; $display("FAIL busy_start_latency: got %0d expected 35", lat); end
    vectors++; if (row !== 8'h74) begin errors++; $display("FAIL busy_start_row: got %h expected 74", row); end
    vectors++; if (gen_count !== 8'd2) begin errors++; $display("FAIL busy_start_gen_count: got %0d expected 2", gen_count); end
    vectors++; if (pulses !== 1) begin errors++; $display("FAIL busy_start_pulses: got %0d expected 1", pulses); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL done_cycle_start_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midrun();
    int pulses, busy_seen, lat, nba;
    logic [2:0] n1, n2, n15;
    @(negedge clk);
    seed = 8'h10; gens = 8'd1; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    // Cycle T+10 is the SAMPLE of cell 4, neighbourhood 010 for seed 0x10.
    vectors++; if ({nb_in1, nb_in2, nb_in3} !== 3'b010) begin errors++; $display("FAIL midrun_nb_cell4: got %b expected 010", {nb_in1, nb_in2, nb_in3}); end
    rst_n = 1'b0;
    #1;
    vectors++; if (row !== 8'h00 || gen_count !== 8'h00) begin errors++; $display("FAIL midrun_reset_regs: got row %h gen_count %h expected 00 00", row, gen_count); end
    vectors++; if ({busy, done, nb_in1, nb_in2, nb_in3} !== 5'b0) begin errors++; $display("FAIL midrun_reset_ctrl: got %b expected 00000", {busy, done, nb_in1, nb_in2, nb_in3}); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0; busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    vectors++; if (pulses !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d pulses expected 0", pulses); end
    vectors++; if (busy_seen !== 0) begin errors++; $display("FAIL midrun_idle_wait: got %0d busy cycles expected 0", busy_seen); end
    launch(8'h01, 8'd1, 0, 1'b0, lat, pulses, nba, n1, n2, n15);
    vectors++; if (row !== 8'h83) begin errors++; $display("FAIL midrun_restart_row: got %h expected 83", row); end
    vectors++; if (lat !== 18) begin errors++; $display("FAIL midrun_restart_latency: got %0d expected 18", lat); end
  endtask

  initial begin
    test_reset();
    test_single_gen();
    test_wrap();
    test_uniform();
    test_zero_gens();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
